// File: rtl/opb_seq_pkg.sv
// Shared definitions for the OPB two-master sequencer: FSM states, read-latency
// limits and owner encoding.
package opb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/opb_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// the master that was not granted last.
module opb_rr_arb2
  import opb_seq_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_grant,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = OWN_M0;
    if (i_req0 && i_req1) begin
      o_grant = ~i_last;
    end else if (i_req1) begin
      o_grant = OWN_M1;
    end
  end

endmodule

// File: rtl/opb_bus_sequencer.sv
// Two-master OPB sequencer: arbitrates M0/M1, issues one-cycle decoder strobes,
// waits the fixed read latency and returns data with a one-cycle ACK.
module opb_bus_sequencer
  import opb_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              OPB_CLK,
  input  logic              OPB_RST,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  output logic              M0_ACK,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  output logic              M1_ACK,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic              DEC_RE,
  output logic              DEC_WE,
  output logic [ADDR_W-1:0] DEC_ADDR,
  output logic [DATA_W-1:0] DEC_WDATA,
  input  logic [DATA_W-1:0] DEC_DO,
  output logic              GRANT,
  output logic              BUSY
);

  // Out-of-range latencies are clamped so the counter width stays fixed.
  localparam int LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int CNT_W = $clog2(RD_LAT_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_C - 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dec_re;
  logic              r_dec_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_busy;

  logic              w_grant;
  logic              w_valid;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  opb_rr_arb2 u_arb (
    .i_req0  (M0_REQ),
    .i_req1  (M1_REQ),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_sel_we    = (w_grant == OWN_M1) ? M1_WE    : M0_WE;
  assign w_sel_addr  = (w_grant == OWN_M1) ? M1_ADDR  : M0_ADDR;
  assign w_sel_wdata = (w_grant == OWN_M1) ? M1_WDATA : M0_WDATA;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_state  <= IDLE;
      r_owner  <= OWN_M0;
      r_last   <= OWN_M1;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_dec_re <= 1'b0;
      r_dec_we <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      // Strobes and ACKs are single-cycle pulses by default.
      r_dec_re <= 1'b0;
      r_dec_we <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner  <= w_grant;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_dec_we <= w_sel_we;
            r_dec_re <= ~w_sel_we;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_ack0  <= (r_owner == OWN_M0);
            r_ack1  <= (r_owner == OWN_M1);
            r_state <= DONE;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner == OWN_M1) begin
              r_rdata1 <= DEC_DO;
            end else begin
              r_rdata0 <= DEC_DO;
            end
            r_ack0  <= (r_owner == OWN_M0);
            r_ack1  <= (r_owner == OWN_M1);
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign DEC_RE    = r_dec_re;
  assign DEC_WE    = r_dec_we;
  assign DEC_ADDR  = r_addr;
  assign DEC_WDATA = r_wdata;
  assign M0_ACK    = r_ack0;
  assign M1_ACK    = r_ack1;
  assign M0_RDATA  = r_rdata0;
  assign M1_RDATA  = r_rdata1;
  assign GRANT     = r_owner;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_opb_bus_sequencer.sv
// Scoreboard bench for opb_bus_sequencer: two instances (read latency 1 and 4)
// driven by directed and random master traffic against a behavioural model.
`timescale 1ns/1ps
module tb_opb_bus_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic          re;
    logic [AW-1:0] a;
  } hist_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done_flag [2];

  // Content the modelled decoder returns for a read of address a.
  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic chk(input int lat, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL L%0d %s actual=%0h required=%0h", lat, nm, act, expv);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 4;

      logic                rst;
      logic [1:0]          req;
      logic [1:0]          we;
      logic [1:0][AW-1:0]  addr;
      logic [1:0][DW-1:0]  wdata;
      logic [1:0]          ack;
      logic [1:0][DW-1:0]  rdata;
      logic                dec_re;
      logic                dec_we;
      logic [AW-1:0]       dec_addr;
      logic [DW-1:0]       dec_wdata;
      logic [DW-1:0]       dec_do;
      logic                grant;
      logic                busy;

      opb_bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
        .OPB_CLK   (clk),
        .OPB_RST   (rst),
        .M0_REQ    (req[0]),
        .M0_WE     (we[0]),
        .M0_ADDR   (addr[0]),
        .M0_WDATA  (wdata[0]),
        .M0_ACK    (ack[0]),
        .M0_RDATA  (rdata[0]),
        .M1_REQ    (req[1]),
        .M1_WE     (we[1]),
        .M1_ADDR   (addr[1]),
        .M1_WDATA  (wdata[1]),
        .M1_ACK    (ack[1]),
        .M1_RDATA  (rdata[1]),
        .DEC_RE    (dec_re),
        .DEC_WE    (dec_we),
        .DEC_ADDR  (dec_addr),
        .DEC_WDATA (dec_wdata),
        .DEC_DO    (dec_do),
        .GRANT     (grant),
        .BUSY      (busy)
      );

      txn_t          exp_q [2][$];
      hist_t         hist [$];
      logic [DW-1:0] rdata_model [2];
      bit            last_model = 1'b1;
      bit [1:0]      req_prev = 2'b00;
      bit            prev_strobe = 1'b0;
      bit            strobe_pend = 1'b0;
      bit            strobe_we = 1'b0;
      int            strobe_own = 0;
      int            strobe_cyc = 0;
      logic [AW-1:0] held_addr = '0;
      int            cyc = 0;
      int            order_q [$];

      // Decoder model: valid data exactly LAT cycles after a read strobe,
      // fresh random garbage on every other cycle.
      always @(negedge clk) begin : slave
        hist_t h;
        hist.push_back({dec_re, dec_addr});
        dec_do = $urandom;
        if (hist.size() > LAT) begin
          h = hist.pop_front();
          if (h.re) dec_do = slave_rd(h.a);
        end
      end

      always @(negedge clk) begin : mon
        txn_t t;
        int   own;
        if (rst) begin
          prev_strobe    = 1'b0;
          strobe_pend    = 1'b0;
          req_prev       = 2'b00;
          last_model     = 1'b1;
          rdata_model[0] = '0;
          rdata_model[1] = '0;
        end else begin
          cyc++;
          if (dec_re || dec_we) begin
            chk(LAT, "strobe_one_hot", 64'(dec_re & dec_we), 64'(0));
            chk(LAT, "strobe_one_cycle", 64'(prev_strobe), 64'(0));
            chk(LAT, "strobe_not_in_flight", 64'(strobe_pend), 64'(0));
            chk(LAT, "strobe_has_req", 64'(req_prev != 2'b00), 64'(1));
            own = (req_prev == 2'b11) ? int'(!last_model) : (req_prev[1] ? 1 : 0);
            chk(LAT, "grant", 64'(grant), 64'(own));
            chk(LAT, "busy_at_strobe", 64'(busy), 64'(1));
            chk(LAT, "exp_pending", 64'(exp_q[own].size()), 64'(1));
            if (exp_q[own].size() > 0) begin
              t = exp_q[own][0];
              chk(LAT, "strobe_kind", 64'(dec_we), 64'(t.we));
              chk(LAT, "dec_addr", 64'(dec_addr), 64'(t.addr));
              chk(LAT, "dec_wdata", 64'(dec_wdata), 64'(t.wdata));
            end
            strobe_pend = 1'b1;
            strobe_we   = dec_we;
            strobe_own  = own;
            strobe_cyc  = cyc;
            held_addr   = dec_addr;
            order_q.push_back(own);
          end else if (strobe_pend) begin
            chk(LAT, "dec_addr_held", 64'(dec_addr), 64'(held_addr));
          end
          if (ack != 2'b00) begin
            chk(LAT, "ack_one_hot", 64'(ack == 2'b11), 64'(0));
            own = ack[1] ? 1 : 0;
            chk(LAT, "ack_in_flight", 64'(strobe_pend), 64'(1));
            chk(LAT, "ack_owner", 64'(own), 64'(strobe_own));
            chk(LAT, "ack_latency", 64'(cyc - strobe_cyc), 64'(strobe_we ? 1 : 1 + LAT));
            if (exp_q[own].size() > 0) begin
              t = exp_q[own].pop_front();
              if (!t.we) rdata_model[own] = slave_rd(t.addr);
            end
            chk(LAT, "m0_rdata", 64'(rdata[0]), 64'(rdata_model[0]));
            chk(LAT, "m1_rdata", 64'(rdata[1]), 64'(rdata_model[1]));
            last_model  = own[0];
            strobe_pend = 1'b0;
          end
          prev_strobe = dec_re | dec_we;
          req_prev    = req;
        end
      end

      task automatic do_txn(input int m, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit drop_early);
        txn_t t;
        bit   got;
        t.we = w; t.addr = a; t.wdata = d;
        exp_q[m].push_back(t);
        req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
          @(posedge clk); #1;
          if (drop_early && (dec_re || dec_we)) begin
            req[m] = 1'b0; we[m] = ~w; addr[m] = $urandom; wdata[m] = $urandom;
          end
          if (ack[m]) got = 1'b1;
        end
        chk(LAT, "ack_arrived", 64'(got), 64'(1));
        if (!got) exp_q[m].delete();
        req[m] = 1'b0;
      endtask

      task automatic run_master(input int m, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
          do_txn(m, 1'($urandom), $urandom, $urandom, 1'b0);
          if (gap > 0) begin
            repeat ($urandom_range(gap, 0)) begin @(posedge clk); #1; end
          end
        end
      endtask

      task automatic chk_all_zero(input string tag);
        chk(LAT, {tag, "_ctl"}, 64'({dec_re, dec_we, ack, busy, grant}), 64'(0));
        chk(LAT, {tag, "_dec_addr"}, 64'(dec_addr), 64'(0));
        chk(LAT, {tag, "_dec_wdata"}, 64'(dec_wdata), 64'(0));
        chk(LAT, {tag, "_m0_rdata"}, 64'(rdata[0]), 64'(0));
        chk(LAT, {tag, "_m1_rdata"}, 64'(rdata[1]), 64'(0));
      endtask

      initial begin : stim
        bit seen;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Simultaneous requests right after reset: M0 takes the first tie.
        order_q.delete();
        fork
          run_master(0, 4, 0);
          run_master(1, 4, 0);
        join
        chk(LAT, "rr_count", 64'(order_q.size()), 64'(8));
        for (int i = 0; i < order_q.size() && i < 8; i++)
          chk(LAT, $sformatf("rr_order_%0d", i), 64'(order_q[i]), 64'(i % 2));

        do_txn(0, 1'b1, 32'h0001_0000, 32'hA5A5_5A5A, 1'b0);
        do_txn(1, 1'b0, 32'h0008_0004, 32'h0, 1'b0);
        do_txn(0, 1'b1, 32'h0002_0040, 32'h0BAD_F00D, 1'b1);
        do_txn(1, 1'b0, 32'h0003_0008, 32'h1111_2222, 1'b1);

        // Reset asserted while the read is waiting on the decoder.
        exp_q[0].push_back({1'b0, 32'h0000_4000, 32'h0});
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_4000; wdata[0] = '0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
          @(posedge clk); #1;
          seen = dec_re;
        end
        chk(LAT, "rst_test_strobe", 64'(seen), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        exp_q[0].delete();
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(LAT, "no_ack_in_rst", 64'(ack), 64'(0));
        rst = 1'b0;
        do_txn(1, 1'b0, 32'h0000_7777, 32'h0, 1'b0);

        fork
          run_master(0, 30, 3);
          run_master(1, 30, 3);
        join
        done_flag[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin : top
    for (int n = 0; n < 20000 && !(done_flag[0] && done_flag[1]); n++) @(posedge clk);
    if (!(done_flag[0] && done_flag[1])) begin
      errors++;
      $display("FAIL sim_timeout actual=unfinished required=finished");
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
